// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: reset PC, FSM state encoding and target-alignment helper for pc_gen.
`default_nettype none

package pc_gen_pkg;

   localparam logic [63:0] RESET_VAL = 64'h0000_0000_8000_0000;

   typedef enum logic [1:0] {
      PCG_BOOT  = 2'd0,
      PCG_ISSUE = 2'd1,
      PCG_IDLE  = 2'd2
   } pcg_state_e;

   function automatic logic [63:0] align_tgt(input logic [63:0] tgt);
      return tgt & ~64'd3;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with in-flight redirect capture and wrong-path flush.
// Optional PC_GEN_MISALIGN_CHK_EN: trap misaligned redirect targets instead of masking them.
`default_nettype none

module pc_gen
   import pc_gen_pkg::*;
#(
   parameter logic [63:0] RESET_PC   = RESET_VAL,
   parameter int          INST_BYTES = 4
) (
   input  logic        core_clk,
   input  logic        core_rst,
   input  logic        core_pc_en,
   input  logic        ifu_pc_pause,
   input  logic        branch_taken,
   input  logic [63:0] branch_pc,
   output logic [63:0] pc,
   output logic        pc_valid,
   output logic        pc_flush,
   output logic        pc_misalign
);

   pcg_state_e  state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic        pc_valid_q, pc_valid_d;
   logic        pend_vld_q, pend_vld_d;
   logic [63:0] pend_pc_q, pend_pc_d;
   logic        accept;
   logic [63:0] tgt;
   logic [63:0] pc_seq;

   assign accept = pc_valid_q & ~ifu_pc_pause;
   assign tgt    = align_tgt(branch_pc);
   assign pc_seq = pend_vld_q ? pend_pc_q : (pc_q + 64'(INST_BYTES));

`ifdef PC_GEN_MISALIGN_CHK_EN
   logic misalign_q, misalign_d;
   logic bad_tgt;
   assign bad_tgt = branch_taken & (branch_pc[1:0] != 2'b00);
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_vld_d = pend_vld_q;
      pend_pc_d  = pend_pc_q;
`ifdef PC_GEN_MISALIGN_CHK_EN
      misalign_d = misalign_q;
`endif
      case (state_q)
         PCG_BOOT: begin
            state_d = core_pc_en ? PCG_ISSUE : PCG_IDLE;
            if (branch_taken) pc_d = tgt;
         end
         PCG_ISSUE: begin
            if (accept) begin
               pc_d       = branch_taken ? tgt : pc_seq;
               pend_vld_d = 1'b0;
               state_d    = core_pc_en ? PCG_ISSUE : PCG_IDLE;
            end else if (branch_taken) begin
               // Fetch still outstanding: park the target, newest redirect wins.
               pend_pc_d  = tgt;
               pend_vld_d = 1'b1;
            end
         end
         PCG_IDLE: begin
            if (branch_taken) pc_d = tgt;
            if (core_pc_en) state_d = PCG_ISSUE;
         end
         default: state_d = PCG_BOOT;
      endcase
`ifdef PC_GEN_MISALIGN_CHK_EN
      // Once trapped, the offending target stays visible on pc until reset.
      if (misalign_q) begin
         state_d    = PCG_IDLE;
         pc_d       = pc_q;
         pend_vld_d = 1'b0;
      end else if (bad_tgt) begin
         misalign_d = 1'b1;
         state_d    = PCG_IDLE;
         pc_d       = branch_pc;
         pend_vld_d = 1'b0;
      end
`endif
      pc_valid_d = (state_d == PCG_ISSUE);
   end

   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         state_q    <= PCG_BOOT;
         pc_q       <= RESET_PC;
         pc_valid_q <= 1'b0;
         pend_vld_q <= 1'b0;
         pend_pc_q  <= '0;
`ifdef PC_GEN_MISALIGN_CHK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc_valid_q <= pc_valid_d;
         pend_vld_q <= pend_vld_d;
         pend_pc_q  <= pend_pc_d;
`ifdef PC_GEN_MISALIGN_CHK_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   assign pc       = pc_q;
   assign pc_valid = pc_valid_q;
   assign pc_flush = accept & (pend_vld_q | branch_taken);
`ifdef PC_GEN_MISALIGN_CHK_EN
   assign pc_misalign = misalign_q;
`else
   assign pc_misalign = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen.
`default_nettype none

module tb_pc_gen;

   logic        core_clk = 1'b0;
   logic        core_rst = 1'b1;
   logic        core_pc_en = 1'b1;
   logic        ifu_pc_pause = 1'b0;
   logic        branch_taken = 1'b0;
   logic [63:0] branch_pc = '0;
   logic [63:0] pc;
   logic        pc_valid;
   logic        pc_flush;
   logic        pc_misalign;

   int n_tests = 0;
   int n_fail  = 0;

   pc_gen dut (
      .core_clk    (core_clk),
      .core_rst    (core_rst),
      .core_pc_en  (core_pc_en),
      .ifu_pc_pause(ifu_pc_pause),
      .branch_taken(branch_taken),
      .branch_pc   (branch_pc),
      .pc          (pc),
      .pc_valid    (pc_valid),
      .pc_flush    (pc_flush),
      .pc_misalign (pc_misalign)
   );

   always #5 core_clk = ~core_clk;

   task automatic tick;
      @(posedge core_clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state
      tick;
      chk("rst_pc", pc, 64'h8000_0000);
      chk("rst_valid", {63'd0, pc_valid}, 64'd0);
      chk("rst_flush", {63'd0, pc_flush}, 64'd0);
      chk("rst_misalign", {63'd0, pc_misalign}, 64'd0);

      // Sequential fetch, no bubbles
      core_rst = 1'b0;
      tick;
      chk("seq0_pc", pc, 64'h8000_0000);
      chk("seq0_valid", {63'd0, pc_valid}, 64'd1);
      tick;
      chk("seq1_pc", pc, 64'h8000_0004);
      tick;
      chk("seq2_pc", pc, 64'h8000_0008);
      tick;
      chk("seq3_pc", pc, 64'h8000_000C);
      tick;
      chk("seq4_pc", pc, 64'h8000_0010);

      // Three-cycle pause holds pc
      ifu_pc_pause = 1'b1;
      settle;
      chk("pause0_pc", pc, 64'h8000_0010);
      chk("pause0_flush", {63'd0, pc_flush}, 64'd0);
      tick;
      chk("pause1_pc", pc, 64'h8000_0010);
      tick;
      chk("pause2_pc", pc, 64'h8000_0010);
      chk("pause2_valid", {63'd0, pc_valid}, 64'd1);
      ifu_pc_pause = 1'b0;
      settle;
      chk("unpause_flush", {63'd0, pc_flush}, 64'd0);
      tick;
      chk("unpause_pc", pc, 64'h8000_0014);

      // Redirect during an outstanding fetch
      ifu_pc_pause = 1'b1;
      branch_taken = 1'b1;
      branch_pc    = 64'h8000_1000;
      settle;
      chk("br_pause_flush", {63'd0, pc_flush}, 64'd0);
      tick;
      branch_taken = 1'b0;
      settle;
      chk("br_pause_pc", pc, 64'h8000_0014);
      tick;
      ifu_pc_pause = 1'b0;
      settle;
      chk("br_acc_flush", {63'd0, pc_flush}, 64'd1);
      tick;
      chk("br_tgt_pc", pc, 64'h8000_1000);
      chk("br_after_flush", {63'd0, pc_flush}, 64'd0);

      // Two redirects while paused: newest wins, single flush
      ifu_pc_pause = 1'b1;
      branch_taken = 1'b1;
      branch_pc    = 64'h8000_2000;
      tick;
      branch_pc    = 64'h8000_3000;
      tick;
      branch_taken = 1'b0;
      ifu_pc_pause = 1'b0;
      settle;
      chk("br2_flush", {63'd0, pc_flush}, 64'd1);
      tick;
      chk("br2_pc", pc, 64'h8000_3000);
      chk("br2_flush_once", {63'd0, pc_flush}, 64'd0);

      // Redirect coincident with accept, misaligned target
      branch_taken = 1'b1;
      branch_pc    = 64'h8000_4002;
      settle;
      chk("coinc_flush", {63'd0, pc_flush}, 64'd1);
      tick;
      branch_taken = 1'b0;
      settle;
`ifdef PC_GEN_MISALIGN_CHK_EN
      chk("mis_pc", pc, 64'h8000_4002);
      chk("mis_valid", {63'd0, pc_valid}, 64'd0);
      chk("mis_flag", {63'd0, pc_misalign}, 64'd1);
      tick;
      chk("mis_hold_pc", pc, 64'h8000_4002);
      chk("mis_hold_valid", {63'd0, pc_valid}, 64'd0);
      chk("mis_hold_flag", {63'd0, pc_misalign}, 64'd1);
`else
      chk("coinc_pc", pc, 64'h8000_4000);
      chk("coinc_valid", {63'd0, pc_valid}, 64'd1);
      chk("coinc_misalign", {63'd0, pc_misalign}, 64'd0);
      tick;
      chk("coinc_next_pc", pc, 64'h8000_4004);
`endif

      // Reset, then wrap-around at the top of the address space
      core_rst = 1'b1;
      tick;
      chk("rst2_pc", pc, 64'h8000_0000);
      chk("rst2_misalign", {63'd0, pc_misalign}, 64'd0);
      core_rst = 1'b0;
      tick;
      chk("rst2_valid", {63'd0, pc_valid}, 64'd1);
      branch_taken = 1'b1;
      branch_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
      settle;
      chk("wrap_br_flush", {63'd0, pc_flush}, 64'd1);
      tick;
      branch_taken = 1'b0;
      settle;
      chk("wrap_top_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
      tick;
      chk("wrap_zero_pc", pc, 64'h0);

      // core_pc_en low: finish current fetch then idle; redirect in IDLE
      core_pc_en = 1'b0;
      tick;
      chk("idle_pc", pc, 64'h4);
      chk("idle_valid", {63'd0, pc_valid}, 64'd0);
      tick;
      chk("idle_hold_pc", pc, 64'h4);
      branch_taken = 1'b1;
      branch_pc    = 64'h8000_5000;
      settle;
      chk("idle_br_flush", {63'd0, pc_flush}, 64'd0);
      tick;
      branch_taken = 1'b0;
      settle;
      chk("idle_br_pc", pc, 64'h8000_5000);
      chk("idle_br_valid", {63'd0, pc_valid}, 64'd0);
      core_pc_en = 1'b1;
      tick;
      chk("resume_pc", pc, 64'h8000_5000);
      chk("resume_valid", {63'd0, pc_valid}, 64'd1);

      // Reset mid-pause with a redirect pending
      ifu_pc_pause = 1'b1;
      branch_taken = 1'b1;
      branch_pc    = 64'h8000_6000;
      tick;
      branch_taken = 1'b0;
      core_rst     = 1'b1;
      tick;
      chk("rst3_pc", pc, 64'h8000_0000);
      chk("rst3_valid", {63'd0, pc_valid}, 64'd0);
      core_rst     = 1'b0;
      ifu_pc_pause = 1'b0;
      tick;
      chk("rst3_first_pc", pc, 64'h8000_0000);
      chk("rst3_nopend_flush", {63'd0, pc_flush}, 64'd0);
      tick;
      chk("rst3_next_pc", pc, 64'h8000_0004);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
